// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM states, address
// regions, the latched request record and the address decoder.
package mem_responder_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    typedef enum logic [1:0] {REG_RAM, REG_CONSOLE, REG_MISS} region_e;

    localparam int          LAT_W                = 4;
    localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h1000_0000;
    localparam logic [31:0] MISS_RDATA           = 32'h0;

    // Request as held across the wait states; byte-offset bits are dropped.
    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } req_t;

    function automatic region_e decode(input logic [29:0] waddr,
                                       input int unsigned words,
                                       input logic [29:0] console_waddr);
        if ({2'b00, waddr} < words) return REG_RAM;
        if (waddr == console_waddr) return REG_CONSOLE;
        return REG_MISS;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Native valid/ready memory bus between the core (master) and a memory
// responder (slave).
interface mem_responder_if;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_responder_sp_ram_be.sv
// Single-port WORDS x 32 RAM with per-byte write enables and a registered
// read port; the read data holds until the next read is issued.
module sp_ram_be #(
    parameter int unsigned WORDS = 1024
) (
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [WORDS];
    logic [31:0] rdata_q;

    // NOTE: the array has no reset; clearing it would force it out of
    // block RAM into flops, and contents must survive a core reset anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves fetches, loads and byte-strobed stores from
// an internal RAM after LATENCY wait states, plus a console byte port.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WORDS        = 1024,
    parameter int unsigned LATENCY      = 1,
    parameter logic [31:0] CONSOLE_ADDR = DEFAULT_CONSOLE_ADDR
) (
    input  logic               clk,
    input  logic               reset,
    mem_responder_if.slave     bus,
    output logic               console_valid,
    output logic [7:0]         console_data,
    output logic               bus_error
);

    localparam int             AW  = $clog2(WORDS);
    localparam logic [LAT_W-1:0] LAT = LAT_W'(LATENCY);

    state_e           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d, in_req, cur;
    logic             ready_q, ready_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_q, wr_d;
    logic             con_valid_q, con_valid_d;
    logic [7:0]       con_data_q, con_data_d;
    logic             err_q, err_d;

    logic             to_resp;
    logic             rd_en;
    logic             is_wr;
    logic             viol;
    region_e          region;
    logic [31:0]      ram_rdata;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^bus.mem_addr[1:0];

    // NOTE: every always_comb output gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        in_req  = '{waddr: bus.mem_addr[31:2], wdata: bus.mem_wdata,
                    wstrb: bus.mem_wstrb,      instr: bus.mem_instr};
        // Decode looks at the live bus in IDLE so LATENCY=0 can respond at once.
        cur     = (state_q == IDLE) ? in_req : req_q;
        region  = decode(cur.waddr, WORDS, CONSOLE_ADDR[31:2]);
        is_wr   = |cur.wstrb;
        viol    = cur.instr & is_wr;

        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        to_resp     = 1'b0;
        ready_d     = 1'b0;
        rd_valid_d  = 1'b0;
        wr_d        = 1'b0;
        con_valid_d = 1'b0;
        con_data_d  = 8'h00;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (bus.mem_valid) begin
                    req_d = in_req;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        to_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            WAIT: begin
                if (!bus.mem_valid) begin
                    state_d = IDLE;
                end else if (cnt_q == LAT_W'(1)) begin
                    state_d = RESP;
                    to_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (to_resp) begin
            ready_d     = 1'b1;
            rd_valid_d  = !is_wr && (region == REG_RAM);
            wr_d        = is_wr && !viol && (region == REG_RAM);
            con_valid_d = is_wr && !viol && (region == REG_CONSOLE) && cur.wstrb[0];
            con_data_d  = con_valid_d ? cur.wdata[7:0] : 8'h00;
            if (region == REG_MISS || viol) err_d = 1'b1;
        end

        rd_en = rd_valid_d;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            ready_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_q        <= 1'b0;
            con_valid_q <= 1'b0;
            con_data_q  <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            ready_q     <= ready_d;
            rd_valid_q  <= rd_valid_d;
            wr_q        <= wr_d;
            con_valid_q <= con_valid_d;
            con_data_q  <= con_data_d;
            err_q       <= err_d;
        end
    end

    // The store commits on the edge closing RESP; reset on that edge cancels it.
    sp_ram_be #(.WORDS(WORDS)) u_ram (
        .clk   (clk),
        .rd_en (rd_en),
        .we    (wr_q & reset),
        .be    (req_q.wstrb),
        .addr  (cur.waddr[AW-1:0]),
        .wdata (req_q.wdata),
        .rdata (ram_rdata)
    );

    assign bus.mem_ready  = ready_q;
    assign bus.mem_rdata  = rd_valid_q ? ram_rdata : MISS_RDATA;
    assign console_valid  = con_valid_q;
    assign console_data   = con_data_q;
    assign bus_error      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: four instances at LATENCY 0, 1, 3 and 15,
// each with its own reset, driven from one linear stimulus sequence.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst_n;
    logic [3:0]  valid;
    logic [3:0]  instr;
    logic [31:0] addr  [4];
    logic [31:0] wdata [4];
    logic [3:0]  wstrb [4];

    logic [3:0]  ready_o;
    logic [31:0] rdata_o    [4];
    logic [3:0]  con_valid_o;
    logic [7:0]  con_data_o [4];
    logic [3:0]  err_o;

    int lat_of [4] = '{0, 1, 3, 15};
    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 15;
        mem_responder_if bus ();
        assign bus.mem_valid = valid[g];
        assign bus.mem_instr = instr[g];
        assign bus.mem_addr  = addr[g];
        assign bus.mem_wdata = wdata[g];
        assign bus.mem_wstrb = wstrb[g];
        assign ready_o[g]    = bus.mem_ready;
        assign rdata_o[g]    = bus.mem_rdata;

        mem_responder #(.LATENCY(L)) dut (
            .clk           (clk),
            .reset         (rst_n[g]),
            .bus           (bus.slave),
            .console_valid (con_valid_o[g]),
            .console_data  (con_data_o[g]),
            .bus_error     (err_o[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input int d, input string tag);
        check({tag, ".ready"}, 32'(ready_o[d]), 32'h0);
        check({tag, ".rdata"}, rdata_o[d], 32'h0);
        check({tag, ".cvalid"}, 32'(con_valid_o[d]), 32'h0);
        check({tag, ".cdata"}, 32'(con_data_o[d]), 32'h0);
    endtask

    // One complete transfer; checks response latency and that the response
    // collapses back to idle one cycle later.
    task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic ins, input string tag,
                        output logic [31:0] rd, output logic cv, output logic [7:0] cd);
        int k;
        valid[d] = 1'b1;
        instr[d] = ins;
        addr[d]  = a;
        wdata[d] = wd;
        wstrb[d] = ws;
        tick();
        k = 0;
        while (ready_o[d] !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check({tag, ".lat"}, k, lat_of[d]);
        rd = rdata_o[d];
        cv = con_valid_o[d];
        cd = con_data_o[d];
        valid[d] = 1'b0;
        instr[d] = 1'b0;
        wstrb[d] = 4'h0;
        tick();
        check_quiet(d, {tag, ".after"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        cv;
        logic [7:0]  cd;
        int          seen;

        rst_n = 4'h0;
        valid = 4'h0;
        instr = 4'h0;
        for (int i = 0; i < 4; i++) begin
            addr[i]  = 32'h0;
            wdata[i] = 32'h0;
            wstrb[i] = 4'h0;
        end
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            check_quiet(i, $sformatf("reset%0d", i));
            check($sformatf("reset%0d.err", i), 32'(err_o[i]), 32'h0);
        end
        rst_n = 4'hF;
        tick();

        // LATENCY=1: full store, read back, partial store, console, miss.
        xfer(1, 32'h40, 32'hCAFE_BABE, 4'hF, 1'b0, "wr40", rd, cv, cd);
        xfer(1, 32'h40, 32'h0, 4'h0, 1'b0, "rd40", rd, cv, cd);
        check("rd40.data", rd, 32'hCAFE_BABE);
        xfer(1, 32'h40, 32'h0000_00AA, 4'b0001, 1'b0, "wr40b", rd, cv, cd);
        xfer(1, 32'h42, 32'h0, 4'h0, 1'b0, "rd40b", rd, cv, cd);
        check("rd40b.data", rd, 32'hCAFE_BAAA);

        xfer(1, 32'h1000_0000, 32'h0000_0041, 4'hF, 1'b0, "con_wr", rd, cv, cd);
        check("con_wr.valid", 32'(cv), 32'h1);
        check("con_wr.data", 32'(cd), 32'h41);
        check("con_wr.err", 32'(err_o[1]), 32'h0);
        xfer(1, 32'h1000_0000, 32'h0, 4'h0, 1'b0, "con_rd", rd, cv, cd);
        check("con_rd.data", rd, 32'h0);
        check("con_rd.valid", 32'(cv), 32'h0);

        xfer(1, 32'h8000_0000, 32'h0, 4'h0, 1'b0, "miss", rd, cv, cd);
        check("miss.data", rd, 32'h0);
        check("miss.err", 32'(err_o[1]), 32'h1);
        for (int i = 0; i < 10; i++) begin
            xfer(1, 32'h40, 32'h0, 4'h0, 1'b0, $sformatf("good%0d", i), rd, cv, cd);
            check($sformatf("good%0d.data", i), rd, 32'hCAFE_BAAA);
        end
        check("miss.sticky", 32'(err_o[1]), 32'h1);

        // LATENCY=3: aborted store, fetch, and a store flagged as a fetch.
        xfer(2, 32'h10, 32'h1111_1111, 4'hF, 1'b0, "pre10", rd, cv, cd);
        valid[2] = 1'b1;
        addr[2]  = 32'h10;
        wdata[2] = 32'h2222_2222;
        wstrb[2] = 4'hF;
        tick();
        valid[2] = 1'b0;
        wstrb[2] = 4'h0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ready_o[2] === 1'b1) seen++;
        end
        check("abort.ready", seen, 0);
        xfer(2, 32'h10, 32'h0, 4'h0, 1'b0, "abort.rd", rd, cv, cd);
        check("abort.data", rd, 32'h1111_1111);
        check("abort.err", 32'(err_o[2]), 32'h0);
        xfer(2, 32'h10, 32'h0, 4'h0, 1'b1, "fetch", rd, cv, cd);
        check("fetch.data", rd, 32'h1111_1111);
        check("fetch.err", 32'(err_o[2]), 32'h0);
        xfer(2, 32'h10, 32'h3333_3333, 4'hF, 1'b1, "ifwr", rd, cv, cd);
        check("ifwr.err", 32'(err_o[2]), 32'h1);
        xfer(2, 32'h10, 32'h0, 4'h0, 1'b0, "ifwr.rd", rd, cv, cd);
        check("ifwr.data", rd, 32'h1111_1111);

        // LATENCY=15: reset in the middle of the wait states of a store.
        xfer(3, 32'h20, 32'h5A5A_5A5A, 4'hF, 1'b0, "pre20_15", rd, cv, cd);
        valid[3] = 1'b1;
        addr[3]  = 32'h20;
        wdata[3] = 32'hDEAD_BEEF;
        wstrb[3] = 4'hF;
        tick();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ready_o[3] === 1'b1) seen++;
        end
        check("rst15.early", seen, 0);
        rst_n[3] = 1'b0;
        tick();
        check_quiet(3, "rst15");
        check("rst15.err", 32'(err_o[3]), 32'h0);
        valid[3] = 1'b0;
        wstrb[3] = 4'h0;
        rst_n[3] = 1'b1;
        tick();
        xfer(3, 32'h20, 32'h0, 4'h0, 1'b0, "rst15.rd", rd, cv, cd);
        check("rst15.data", rd, 32'h5A5A_5A5A);

        // LATENCY=0: reset lands on the response cycle of a store.
        xfer(0, 32'h20, 32'h1234_5678, 4'hF, 1'b0, "pre20_0", rd, cv, cd);
        valid[0] = 1'b1;
        addr[0]  = 32'h20;
        wdata[0] = 32'hDEAD_BEEF;
        wstrb[0] = 4'hF;
        tick();
        rst_n[0] = 1'b0;
        tick();
        check_quiet(0, "rst0");
        valid[0] = 1'b0;
        wstrb[0] = 4'h0;
        rst_n[0] = 1'b1;
        tick();
        xfer(0, 32'h20, 32'h0, 4'h0, 1'b0, "rst0.rd", rd, cv, cd);
        check("rst0.data", rd, 32'h1234_5678);

        // RAM edge: last word hits, the next word is a miss and must not alias.
        xfer(0, 32'hFFC, 32'h0BAD_F00D, 4'hF, 1'b0, "top.wr", rd, cv, cd);
        xfer(0, 32'hFFC, 32'h0, 4'h0, 1'b0, "top.rd", rd, cv, cd);
        check("top.data", rd, 32'h0BAD_F00D);
        check("top.err", 32'(err_o[0]), 32'h0);
        xfer(0, 32'h1000, 32'h0, 4'h0, 1'b0, "past.rd", rd, cv, cd);
        check("past.data", rd, 32'h0);
        check("past.err", 32'(err_o[0]), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
